msg_loop: RTL and testbench

MSG_LOOP -- requirements
Module: msg_loop

---
 rtl/msg_loop_pkg.sv | 16 +
 rtl/msg_loop_uart_rx.sv | 70 +++++++
 rtl/msg_loop.sv | 115 +++++++++++
 tb/tb_msg_loop.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/msg_loop_pkg.sv
// msg_loop_pkg: shared FSM encodings, default backspace code and 8N1 frame constants
package msg_loop_pkg;
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_SEND  = 2'd2;
  localparam logic [1:0] ST_GAP   = 2'd3;
  localparam logic [1:0] RX_IDLE  = 2'd0;
  localparam logic [1:0] RX_START = 2'd1;
  localparam logic [1:0] RX_DATA  = 2'd2;
  localparam logic [1:0] RX_STOP  = 2'd3;
  localparam logic [7:0] BS_DEFAULT      = 8'h08;
  localparam int         FRAME_DATA_BITS = 8;
  localparam logic       FRAME_START     = 1'b0;
  localparam logic       FRAME_STOP      = 1'b1;
  localparam logic       LINE_IDLE       = 1'b1;
endpackage

// File: rtl/msg_loop_uart_rx.sv
// uart_rx: 8N1-style serial receiver with mid-bit sampling
//   sysclk, reset_n : clock, async active-low reset
//   i_rx            : already-synchronised serial input, idle high
//   o_valid         : one-cycle pulse, o_data holds a frame with a good stop bit
//   o_frame_err     : one-cycle pulse, frame discarded because stop bit was 0
//   o_data          : received character, LSB first on the line
module uart_rx
  import msg_loop_pkg::*;
#(
  parameter int DATA_W       = FRAME_DATA_BITS,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic              sysclk,
  input  logic              reset_n,
  input  logic              i_rx,
  output logic              o_valid,
  output logic              o_frame_err,
  output logic [DATA_W-1:0] o_data
);
  localparam int CNT_W = $clog2(CLKS_PER_BIT) + 1;
  localparam int BIT_W = $clog2(DATA_W) + 1;
  logic [1:0]        r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [BIT_W-1:0]  r_bit;
  logic              r_prev, r_valid, r_ferr;
  logic [DATA_W-1:0] r_data;
  logic [CNT_W-1:0]  w_lim;
  // the start bit is re-checked after half a bit, every later sample one full bit on
  assign w_lim = (r_state == RX_START) ? CNT_W'(CLKS_PER_BIT / 2 - 1) : CNT_W'(CLKS_PER_BIT - 1);
  always_ff @(posedge sysclk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= RX_IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_prev  <= 1'b1;
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
      r_data  <= '0;
    end else begin
      r_prev  <= i_rx;
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
      if (r_state == RX_IDLE) begin
        if (r_prev && !i_rx) begin
          r_state <= RX_START;
          r_cnt   <= '0;
        end
      end else if (r_cnt != w_lim) begin
        r_cnt <= r_cnt + 1'b1;
      end else begin
        r_cnt <= '0;
        if (r_state == RX_START) begin
          r_state <= i_rx ? RX_IDLE : RX_DATA;
          r_bit   <= '0;
        end else if (r_state == RX_DATA) begin
          r_data <= {i_rx, r_data[DATA_W-1:1]};
          r_bit  <= r_bit + 1'b1;
          if (r_bit == BIT_W'(DATA_W - 1)) r_state <= RX_STOP;
        end else begin
          r_valid <= i_rx;
          r_ferr  <= !i_rx;
          r_state <= RX_IDLE;
        end
      end
    end
  end
  assign o_valid     = r_valid;
  assign o_frame_err = r_ferr;
  assign o_data      = r_data;
endmodule

// File: rtl/msg_loop.sv
// msg_loop: stores received serial characters (with backspace) and replays them on play
//   sysclk, reset_n : clock, async active-low reset
//   rx / tx         : serial in / out, idle high; tx echoes rx while idle if ECHO
//   play, clear     : single-cycle replay request / empty-message request
//   busy            : playback in progress
//   count           : number of stored characters
//   overflow        : sticky, a character was dropped at MAX_LEN
module msg_loop
  import msg_loop_pkg::*;
#(
  parameter int              DATA_W       = FRAME_DATA_BITS,
  parameter int              DEPTH        = 256,
  parameter int              MAX_LEN      = 160,
  parameter int              CLKS_PER_BIT = 10417,
  parameter logic [DATA_W-1:0] BS_CODE    = DATA_W'(BS_DEFAULT),
  parameter int              ECHO         = 1,
  parameter int              GAP_BITS     = 2
) (
  input  logic                     sysclk,
  input  logic                     reset_n,
  input  logic                     rx,
  input  logic                     play,
  input  logic                     clear,
  output logic                     tx,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
);
  localparam int ADDR_W = $clog2(DEPTH);
  localparam int CNT_W  = $clog2(CLKS_PER_BIT) + 1;
  localparam int BIT_W  = $clog2(DATA_W + GAP_BITS + 2) + 1;
  localparam logic [ADDR_W:0] LEN = (ADDR_W + 1)'(MAX_LEN);
  logic              r_rx_m, r_rx_s, r_overflow;
  logic [1:0]        r_state;
  logic [ADDR_W:0]   r_count, r_rd_ptr;
  logic [DATA_W+1:0] r_sh;
  logic [CNT_W-1:0]  r_tick;
  logic [BIT_W-1:0]  r_bit;
  logic [DATA_W-1:0] mem [DEPTH];
  logic              w_valid, w_ferr, w_store, w_bs, w_wr, w_tick_end;
  logic [DATA_W-1:0] w_rx_data;
  uart_rx #(.DATA_W(DATA_W), .CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .sysclk(sysclk), .reset_n(reset_n), .i_rx(r_rx_s),
    .o_valid(w_valid), .o_frame_err(w_ferr), .o_data(w_rx_data)
  );
  // characters arriving during playback or under clear are dropped
  assign w_store    = w_valid && !w_ferr && r_state == ST_IDLE && !clear;
  assign w_bs       = w_rx_data == BS_CODE;
  assign w_wr       = w_store && !w_bs && r_count < LEN;
  assign w_tick_end = r_tick == CNT_W'(CLKS_PER_BIT - 1);
  always_ff @(posedge sysclk) begin
    if (w_wr) mem[r_count[ADDR_W-1:0]] <= w_rx_data;
  end
  always_ff @(posedge sysclk or negedge reset_n) begin
    if (!reset_n) begin
      r_rx_m     <= 1'b1;
      r_rx_s     <= 1'b1;
      r_state    <= ST_IDLE;
      r_count    <= '0;
      r_rd_ptr   <= '0;
      r_overflow <= 1'b0;
      r_sh       <= '1;
      r_tick     <= '0;
      r_bit      <= '0;
    end else begin
      r_rx_m <= rx;
      r_rx_s <= r_rx_m;
      if (clear) begin
        r_state    <= ST_IDLE;
        r_count    <= '0;
        r_overflow <= 1'b0;
      end else begin
        if (w_store) begin
          if (w_bs) begin
            if (r_count != '0) r_count <= r_count - 1'b1;
          end else if (r_count < LEN) r_count <= r_count + 1'b1;
          else r_overflow <= 1'b1;
        end
        if (r_state == ST_IDLE) begin
          if (play && r_count != '0) begin
            r_state  <= ST_FETCH;
            r_rd_ptr <= '0;
          end
        end else if (r_state == ST_FETCH) begin
          // synchronous read straight into the outgoing frame
          r_sh    <= {FRAME_STOP, mem[r_rd_ptr[ADDR_W-1:0]], FRAME_START};
          r_tick  <= '0;
          r_bit   <= '0;
          r_state <= ST_SEND;
        end else if (!w_tick_end) begin
          r_tick <= r_tick + 1'b1;
        end else begin
          r_tick <= '0;
          r_sh   <= {LINE_IDLE, r_sh[DATA_W+1:1]};
          r_bit  <= r_bit + 1'b1;
          if (r_state == ST_SEND && r_bit == BIT_W'(DATA_W + 1)) begin
            r_state <= ST_GAP;
            r_bit   <= '0;
          end else if (r_state == ST_GAP && r_bit == BIT_W'(GAP_BITS - 1)) begin
            r_bit    <= '0;
            r_rd_ptr <= r_rd_ptr + 1'b1;
            r_state  <= (r_rd_ptr + 1'b1 == r_count) ? ST_IDLE : ST_FETCH;
          end
        end
      end
    end
  end
  // clear forces the line idle in the same cycle it is asserted
  assign tx = clear ? LINE_IDLE :
              r_state == ST_SEND ? r_sh[0] :
              (r_state == ST_IDLE && ECHO != 0) ? r_rx_s : LINE_IDLE;
  assign busy     = r_state != ST_IDLE;
  assign count    = r_count;
  assign overflow = r_overflow;
endmodule

// File: tb/tb_msg_loop.sv
// tb_msg_loop: directed and randomized checks of msg_loop against a queue-based message model
module tb_msg_loop;
  localparam int CPB = 16;
  localparam int MAXL = 4;
  localparam logic [7:0] BS = 8'h08;
  logic sysclk = 1'b0, reset_n = 1'b0, rx = 1'b1, play = 1'b0, clear = 1'b0;
  logic tx, busy, overflow, tx0, busy0, overflow0;
  logic [3:0] count, count0;
  int cyc = 0, n_chk = 0, n_fail = 0;
  logic [7:0] q[$];
  logic m_ovf = 1'b0;
  msg_loop #(.DEPTH(8), .MAX_LEN(MAXL), .CLKS_PER_BIT(CPB), .ECHO(1), .GAP_BITS(2)) dut (
    .sysclk(sysclk), .reset_n(reset_n), .rx(rx), .play(play), .clear(clear),
    .tx(tx), .busy(busy), .count(count), .overflow(overflow));
  msg_loop #(.DEPTH(8), .MAX_LEN(MAXL), .CLKS_PER_BIT(CPB), .ECHO(0), .GAP_BITS(2)) dut0 (
    .sysclk(sysclk), .reset_n(reset_n), .rx(rx), .play(play), .clear(clear),
    .tx(tx0), .busy(busy0), .count(count0), .overflow(overflow0));
  always #5 sysclk = ~sysclk;
  always @(posedge sysclk) cyc <= cyc + 1;
  initial begin
    repeat (90000) @(posedge sysclk);
    $display("FAIL watchdog: cycle budget exhausted at %0d, required finish earlier", cyc);
    $fatal(1);
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) @(negedge sysclk);
  endtask
  task automatic send_frame(input logic [7:0] d, input logic stop);
    rx = 1'b0; tick(CPB);
    for (int i = 0; i < 8; i++) begin rx = d[i]; tick(CPB); end
    rx = stop; tick(CPB);
    rx = 1'b1; tick(2 * CPB);
  endtask
  task automatic model_char(input logic [7:0] d);
    if (d == BS) begin
      if (q.size() > 0) void'(q.pop_back());
    end else if (q.size() < MAXL) q.push_back(d);
    else m_ovf = 1'b1;
  endtask
  task automatic send_char(input logic [7:0] d);
    send_frame(d, 1'b1);
    model_char(d);
  endtask
  task automatic do_clear();
    clear = 1'b1; tick(1); clear = 1'b0;
    q.delete(); m_ovf = 1'b0;
  endtask
  task automatic check_state(input string tag);
    chk({tag, "_count"}, count, q.size());
    chk({tag, "_overflow"}, overflow, m_ovf);
  endtask
  task automatic wait_tx_low(input string tag);
    int w = 0;
    while (tx !== 1'b0 && w < 40 * CPB) begin tick(1); w++; end
    chk({tag, "_start_seen"}, tx, 0);
  endtask
  task automatic recv_tx(input string tag, output logic [7:0] d, output int t0);
    d = '0;
    wait_tx_low(tag);
    t0 = cyc;
    tick(CPB / 2);
    chk({tag, "_start_mid"}, tx, 0);
    for (int i = 0; i < 8; i++) begin tick(CPB); d[i] = tx; end
    tick(CPB);
    chk({tag, "_stop"}, tx, 1);
  endtask
  task automatic play_check(input string tag);
    int n, t, tp;
    logic [7:0] d;
    n = q.size(); tp = 0;
    play = 1'b1; tick(1); play = 1'b0;
    chk({tag, "_busy_start"}, busy, 1);
    for (int i = 0; i < n; i++) begin
      recv_tx(tag, d, t);
      chk({tag, "_char"}, d, q[i]);
      if (i > 0) chk({tag, "_frame_spacing"}, t - tp, 12 * CPB + 1);
      tp = t;
    end
    tick(tp + 12 * CPB - 1 - cyc);
    chk({tag, "_busy_last_gap"}, busy, 1);
    tick(1);
    chk({tag, "_busy_end"}, busy, 0);
  endtask
  task automatic abort_test(input bit use_reset);
    string tag;
    tag = use_reset ? "rst_abort" : "clr_abort";
    send_char(8'($urandom)); send_char(8'($urandom));
    play = 1'b1; tick(1); play = 1'b0;
    wait_tx_low(tag);
    tick(CPB + CPB / 2);
    chk({tag, "_busy_before"}, busy, 1);
    if (use_reset) begin
      reset_n = 1'b0; tick(1);
      chk({tag, "_tx"}, tx, 1);
      chk({tag, "_busy"}, busy, 0);
      reset_n = 1'b1;
      q.delete(); m_ovf = 1'b0;
    end else begin
      clear = 1'b1; #1;
      chk({tag, "_tx_same_cycle"}, tx, 1);
      tick(1); clear = 1'b0;
      q.delete(); m_ovf = 1'b0;
      chk({tag, "_tx"}, tx, 1);
      chk({tag, "_busy"}, busy, 0);
    end
    check_state(tag);
    tick(2 * CPB);
    send_char(8'($urandom_range(32, 126))); send_char(8'($urandom_range(32, 126)));
    check_state({tag, "_reload"});
    play_check({tag, "_replay"});
  endtask
  initial begin
    logic rv [16];
    tick(3);
    chk("reset_tx", tx, 1);
    chk("reset_busy", busy, 0);
    chk("reset_count", count, 0);
    chk("reset_overflow", overflow, 0);
    chk("reset_tx_noecho", tx0, 1);
    chk("reset_state_noecho", {busy0, overflow0, count0}, 0);
    reset_n = 1'b1;
    tick(2);
    for (int i = 0; i < 16; i++) begin
      rv[i] = 1'($urandom);
      rx = rv[i];
      tick(1);
      if (i >= 1) chk("echo_latency", tx, rv[i-1]);
      chk("echo_off", tx0, 1);
    end
    rx = 1'b1; tick(12 * CPB);
    do_clear();
    check_state("after_echo");
    send_char(8'h48); send_char(8'h49);
    check_state("hi_load");
    fork
      play_check("hi");
      begin
        tick(CPB);
        send_frame(8'($urandom_range(32, 126)), 1'b1);
        play = 1'b1; tick(1); play = 1'b0;
      end
    join
    check_state("hi_frozen");
    tick(4 * CPB);
    chk("play_while_busy_ignored", busy, 0);
    do_clear();
    send_char(8'h41); send_char(8'h42); send_char(BS); send_char(8'h43);
    check_state("abc");
    play_check("abc");
    do_clear();
    send_char(BS);
    check_state("bs_empty");
    play = 1'b1; tick(1); play = 1'b0;
    chk("play_empty_ignored", busy, 0);
    for (int i = 0; i < 5; i++) send_char(8'($urandom_range(32, 126)));
    check_state("ovf");
    play_check("ovf");
    do_clear();
    check_state("ovf_clear");
    send_char(8'h55);
    send_frame(8'($urandom_range(32, 126)), 1'b0);
    check_state("frame_err");
    rx = 1'b0; tick(CPB * 3 / 10); rx = 1'b1; tick(2 * CPB);
    check_state("glitch");
    do_clear();
    for (int i = 0; i < 8; i++) send_char(($urandom_range(0, 3) == 0) ? BS : 8'($urandom));
    check_state("rand");
    if (q.size() > 0) play_check("rand");
    do_clear();
    abort_test(1'b0);
    do_clear();
    abort_test(1'b1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
